stdp_update_sequencer: RTL and testbench
========================================

Name: stdp_update_sequencer

Overview:
- Controller that sequences one STDP weight-update sweep over all synapses of a post-synaptic neuron.
- Per synapse it drives, in order:
  - the weight-RAM read address;
  - the pre-neuron mux select;
  - a write-back address/enable delayed by the datapath latency, for the timing-difference encoder → LUT → adder path.
- Replaces the free-running counter pair. Gives start/done handshake, stall support and clean drain of in-flight updates.

Parameters:
- NUM_SYN, 16, number of synapses swept per update (≥2, ≤2**ADDR_WIDTH)
- ADDR_WIDTH, 4, width of RAM read/write addresses and mux select
- PIPE_LAT, 2, cycles from rd_addr issue to matching write-back (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a sweep; sampled only in IDLE
- hold  in  1  stall: freezes issue counter and write delay line
- busy  out  1  sweep in progress (ISSUE or DRAIN)
- done  out  1  one-cycle pulse after the last write-back
- rd_en  out  1  read address valid this cycle
- rd_addr  out  ADDR_WIDTH  weight-RAM read address; also the pre-neuron mux select
- pipe_en  out  1  clock-enable for datapath pipeline registers (= ~hold)
- wr_en  out  1  weight-RAM write enable
- wr_addr  out  ADDR_WIDTH  weight-RAM write address

Behaviour:
- Reset: state=IDLE, issue counter=0, delay line cleared. All outputs 0 except pipe_en=1.
- rst mid-sweep aborts immediately: no further wr_en, no done.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Outputs inactive.
  - start=1 at edge E0 → ISSUE, counter=0.
  - start in any other state is ignored (no queueing).
- ISSUE:
  - rd_en=1, rd_addr=counter.
  - Each edge with hold=0: counter+1 and (valid=1, addr=counter) pushed into the delay line.
  - When counter=NUM_SYN-1 and hold=0 → DRAIN.
  - With hold=1: counter, rd_addr and delay line frozen; rd_en stays 1 and the address repeats.
- Delay line:
  - PIPE_LAT-deep shift register of {valid, addr}.
  - Shifts only when hold=0; DRAIN pushes valid=0.
  - wr_en = tail.valid & ~hold; wr_addr = tail.addr. wr_addr is 0 when tail is invalid.
- DRAIN:
  - rd_en=0.
  - Advances when the delay line holds no valid entry beyond the tail currently being written. Last write occurs, then → DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then → IDLE. start during DONE is ignored.
- busy=1 in ISSUE and DRAIN only.
- Timing with hold=0 throughout:
  - rd_addr=k in cycle after edge E0+k.
  - wr_en with wr_addr=k in cycle after edge E0+k+PIPE_LAT.
  - done in cycle after edge E0+NUM_SYN+PIPE_LAT (edge E0+18 at defaults).
- Each hold-high cycle delays every later event by one cycle.
- Every address 0..NUM_SYN-1 is written exactly once per sweep, in ascending order.
- Counter never exceeds NUM_SYN-1.
- Read/write on the same address never coincide in one cycle, because PIPE_LAT ≥ 1.
- Arithmetic is unsigned. Counter width is ADDR_WIDTH; there is no wrap within a sweep.

Optional Feature:
- Macro: STDP_REWARD_GATE_EN
- Defined:
  - Adds input port reward (1 bit), sampled into a flag at the start-accept edge E0.
  - If the flag is 0, wr_en is forced to 0 for the whole sweep.
  - Sequencing, rd_en, busy and done timing are unchanged.
  - Models reward-modulated STDP.
- Undefined: no reward port; every sweep writes back.

Test Plan:
- Basic sweep, defaults: start pulse at edge 0.
  - rd_addr 0..15 on cycles 1..16.
  - wr_en on cycles 3..18 with wr_addr 0..15.
  - done=1 exactly on cycle 19; busy low from cycle 19.
- Stall: hold=1 for 3 cycles while rd_addr=5.
  - rd_addr holds 5 for 4 cycles; wr_en=0 during hold; no address skipped or duplicated.
  - done at cycle 22.
- Ignored start: start pulses during ISSUE, DRAIN and DONE.
  - Exactly one sweep (16 writes) and one done pulse; returns to IDLE.
- Reset mid-sweep: rst=1 at cycle 8.
  - All outputs 0 the next cycle, no done, no wr_en.
  - A new start afterwards produces a full 16-write sweep from address 0.
- Parameter variant NUM_SYN=8, PIPE_LAT=3.
  - wr_addr 0..7 on cycles 4..11; done on cycle 12.
- STDP_REWARD_GATE_EN:
  - reward=0 at start → zero wr_en pulses, done still on cycle 19.
  - reward=1 → 16 writes.

Source files
------------

// File: rtl/stdp_update_sequencer.sv
// Sequences one STDP weight-update sweep: issues read addresses, then write-backs delayed by PIPE_LAT.
// Optional macro STDP_REWARD_GATE_EN adds a reward input that gates all write-backs of a sweep.
module stdp_update_sequencer #(
  parameter int NUM_SYN    = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef STDP_REWARD_GATE_EN
  input  logic                  reward,
`endif
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  pipe_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | one read address per unstalled cycle
  // DRAIN | reads finished, in-flight write-backs emptying
  // DONE  | single-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_SYN - 1);
  localparam int TAIL = PIPE_LAT - 1;

  state_t                               state_q, state_d;
  logic [ADDR_WIDTH-1:0]                cnt_q, cnt_d;
  logic [PIPE_LAT-1:0]                  vld_q, vld_d;
  logic [PIPE_LAT-1:0][ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                                 pend;
`ifdef STDP_REWARD_GATE_EN
  logic                                 gate_q, gate_d;
`endif

  // Any valid entry ahead of the tail means write-backs are still in flight.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) pend = pend | vld_q[i];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
`ifdef STDP_REWARD_GATE_EN
    gate_d  = gate_q;
`endif
    if (!hold) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1];
        addr_d[i] = addr_q[i-1];
      end
      vld_d[0]  = (state_q == S_ISSUE);
      addr_d[0] = (state_q == S_ISSUE) ? cnt_q : '0;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
`ifdef STDP_REWARD_GATE_EN
          gate_d  = reward;
`endif
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          if (cnt_q == LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!hold && !pend) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      addr_q  <= '0;
`ifdef STDP_REWARD_GATE_EN
      gate_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
`ifdef STDP_REWARD_GATE_EN
      gate_q  <= gate_d;
`endif
    end
  end

  assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign rd_en   = (state_q == S_ISSUE);
  assign rd_addr = rd_en ? cnt_q : '0;
  assign pipe_en = ~hold;
  assign wr_addr = vld_q[TAIL] ? addr_q[TAIL] : '0;
`ifdef STDP_REWARD_GATE_EN
  assign wr_en   = vld_q[TAIL] & ~hold & gate_q;
`else
  assign wr_en   = vld_q[TAIL] & ~hold;
`endif

endmodule

// File: tb/tb_stdp_update_sequencer.sv
// Bench for stdp_update_sequencer: two parameterisations (16/2 and 8/3) against a progress-count model.
// Honours STDP_REWARD_GATE_EN when defined.
module tb_stdp_update_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, hold = 1'b0;
  logic nx_rst = 1'b0, nx_start = 1'b0, nx_hold = 1'b0;
`ifdef STDP_REWARD_GATE_EN
  logic reward = 1'b1, nx_reward = 1'b1;
`endif

  logic       busy0, done0, rd_en0, pipe_en0, wr_en0;
  logic [3:0] rd_addr0, wr_addr0;
  logic       busy1, done1, rd_en1, pipe_en1, wr_en1;
  logic [2:0] rd_addr1, wr_addr1;

  always #5 clk = ~clk;

  stdp_update_sequencer #(.NUM_SYN(16), .ADDR_WIDTH(4), .PIPE_LAT(2)) u0 (
    .clk(clk), .rst(rst), .start(start),
`ifdef STDP_REWARD_GATE_EN
    .reward(reward),
`endif
    .hold(hold), .busy(busy0), .done(done0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .pipe_en(pipe_en0), .wr_en(wr_en0), .wr_addr(wr_addr0));

  stdp_update_sequencer #(.NUM_SYN(8), .ADDR_WIDTH(3), .PIPE_LAT(3)) u1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef STDP_REWARD_GATE_EN
    .reward(reward),
`endif
    .hold(hold), .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .pipe_en(pipe_en1), .wr_en(wr_en1), .wr_addr(wr_addr1));

  // Model: a sweep is just "p unstalled edges since start"; outputs follow from p.
  int ns [2] = '{16, 8};
  int pl [2] = '{2, 3};
  bit act [2];
  int p [2];
  bit rf [2];

  int nchk = 0, nerr = 0;
  int cyc = 0, e0 = 0;
  int done_c [2], done_n [2], wr_n [2], first_wr [2], ord_err [2], nxt [2], rd5_n [2];
  int ob [2][7];

  task automatic chk(input string name, input int got, input int exp_v);
    nchk++;
    if (got != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp_v, cyc - e0 + 1);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 2; i++) begin
      done_c[i] = -1; done_n[i] = 0; wr_n[i] = 0; first_wr[i] = -1;
      ord_err[i] = 0; rd5_n[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) act[i] = 1'b0;
      else if (!act[i]) begin
        if (start) begin
          act[i] = 1'b1; p[i] = 0;
`ifdef STDP_REWARD_GATE_EN
          rf[i] = reward;
`else
          rf[i] = 1'b1;
`endif
        end
      end else if (p[i] == ns[i] + pl[i]) act[i] = 1'b0;
      else if (!hold) p[i]++;
    end
    #2;
    rst = nx_rst; start = nx_start; hold = nx_hold;
`ifdef STDP_REWARD_GATE_EN
    reward = nx_reward;
`endif
    @(negedge clk);
    ob[0] = '{int'(busy0), int'(done0), int'(rd_en0), int'(rd_addr0), int'(pipe_en0), int'(wr_en0), int'(wr_addr0)};
    ob[1] = '{int'(busy1), int'(done1), int'(rd_en1), int'(rd_addr1), int'(pipe_en1), int'(wr_en1), int'(wr_addr1)};
    for (int i = 0; i < 2; i++) begin
      int eb, ed, er, era, ew, ewa;
      bit wv;
      eb = 0; ed = 0; er = 0; era = 0; ew = 0; ewa = 0; wv = 1'b0;
      if (act[i]) begin
        eb  = (p[i] < ns[i] + pl[i]) ? 1 : 0;
        ed  = (p[i] == ns[i] + pl[i]) ? 1 : 0;
        er  = (p[i] < ns[i]) ? 1 : 0;
        era = er ? p[i] : 0;
        wv  = (p[i] >= pl[i]) && (p[i] < ns[i] + pl[i]);
        ewa = wv ? p[i] - pl[i] : 0;
        ew  = (wv && !hold && rf[i]) ? 1 : 0;
      end
      chk($sformatf("u%0d.busy", i), ob[i][0], eb);
      chk($sformatf("u%0d.done", i), ob[i][1], ed);
      chk($sformatf("u%0d.rd_en", i), ob[i][2], er);
      chk($sformatf("u%0d.rd_addr", i), ob[i][3], era);
      chk($sformatf("u%0d.pipe_en", i), ob[i][4], hold ? 0 : 1);
      chk($sformatf("u%0d.wr_en", i), ob[i][5], ew);
      chk($sformatf("u%0d.wr_addr", i), ob[i][6], ewa);
      // Log for hand-computed pins
      if (ob[i][1] != 0) begin done_c[i] = cyc - e0 + 1; done_n[i]++; end
      if (ob[i][0] == 0) nxt[i] = 0;
      else if (ob[i][5] != 0) begin
        if (ob[i][6] != nxt[i]) ord_err[i]++;
        nxt[i]++;
        wr_n[i]++;
        if (first_wr[i] < 0) first_wr[i] = cyc - e0 + 1;
      end
      if (ob[i][2] != 0 && ob[i][3] == 5) rd5_n[i]++;
    end
  endtask

  task automatic sweep_start();
    nx_start = 1'b1;
    tick();
    nx_start = 1'b0;
    e0 = cyc + 1;
  endtask

  task automatic plain_sweep(input int cycles);
    clear_log();
    sweep_start();
    for (int c = 1; c <= cycles; c++) tick();
  endtask

  initial begin
    int snap_w, snap_d;
    clear_log();
    nx_rst = 1'b1; tick(); tick();
    nx_rst = 1'b0; tick();
    chk("reset.busy", int'(busy0), 0);
    chk("reset.done", int'(done0), 0);
    chk("reset.rd_en", int'(rd_en0), 0);
    chk("reset.wr_en", int'(wr_en0), 0);
    chk("reset.pipe_en", int'(pipe_en0), 1);
    tick();

    // Basic sweep
    plain_sweep(24);
    chk("basic.first_wr0", first_wr[0], 3);
    chk("basic.first_wr1", first_wr[1], 4);
    chk("basic.done_cyc0", done_c[0], 19);
    chk("basic.done_cyc1", done_c[1], 12);
    chk("basic.writes0", wr_n[0], 16);
    chk("basic.writes1", wr_n[1], 8);
    chk("basic.done_n0", done_n[0], 1);
    chk("basic.order0", ord_err[0], 0);
    chk("basic.order1", ord_err[1], 0);

    // Stall: hold during cycles 6..8 while rd_addr=5
    clear_log();
    sweep_start();
    for (int c = 1; c <= 28; c++) begin
      nx_hold = (c >= 6 && c <= 8);
      tick();
    end
    nx_hold = 1'b0;
    chk("stall.rd5_cycles0", rd5_n[0], 4);
    chk("stall.done_cyc0", done_c[0], 22);
    chk("stall.done_cyc1", done_c[1], 15);
    chk("stall.writes0", wr_n[0], 16);
    chk("stall.order0", ord_err[0], 0);
    chk("stall.writes1", wr_n[1], 8);

    // Ignored starts during ISSUE, DRAIN, DONE
    clear_log();
    sweep_start();
    for (int c = 1; c <= 26; c++) begin
      nx_start = (c == 5 || c == 17 || c == 19);
      tick();
    end
    nx_start = 1'b0;
    chk("ignstart.writes0", wr_n[0], 16);
    chk("ignstart.done_n0", done_n[0], 1);
    chk("ignstart.idle0", int'(busy0), 0);
    for (int c = 0; c < 20; c++) tick();

    // Reset mid-sweep at cycle 8
    clear_log();
    sweep_start();
    for (int c = 1; c <= 9; c++) begin
      nx_rst = (c == 8);
      tick();
    end
    nx_rst = 1'b0;
    chk("midrst.busy0", int'(busy0), 0);
    chk("midrst.rd_en0", int'(rd_en0), 0);
    chk("midrst.rd_addr0", int'(rd_addr0), 0);
    chk("midrst.wr_en0", int'(wr_en0), 0);
    chk("midrst.wr_addr0", int'(wr_addr0), 0);
    chk("midrst.busy1", int'(busy1), 0);
    snap_w = wr_n[0]; snap_d = done_n[0];
    for (int c = 0; c < 20; c++) tick();
    chk("midrst.no_wr_after", wr_n[0] - snap_w, 0);
    chk("midrst.no_done", done_n[0] - snap_d, 0);
    plain_sweep(24);
    chk("midrst.resweep_writes", wr_n[0], 16);
    chk("midrst.resweep_first", first_wr[0], 3);
    chk("midrst.resweep_done", done_c[0], 19);
    chk("midrst.resweep_order", ord_err[0], 0);

`ifdef STDP_REWARD_GATE_EN
    nx_reward = 1'b0;
    plain_sweep(24);
    chk("reward0.writes0", wr_n[0], 0);
    chk("reward0.done_cyc0", done_c[0], 19);
    nx_reward = 1'b1;
    plain_sweep(24);
    chk("reward1.writes0", wr_n[0], 16);
`endif

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      nx_rst   = ($urandom_range(0, 199) == 0);
      nx_start = ($urandom_range(0, 9) == 0);
      nx_hold  = ($urandom_range(0, 4) == 0);
`ifdef STDP_REWARD_GATE_EN
      nx_reward = $urandom_range(0, 1) != 0;
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
